multi_cycle_adder: RTL
======================

# multi_cycle_adder

Parametrised sequential adder/subtractor: adds two WIDTH-bit operands CHUNK bits per clock through one CHUNK-bit ripple adder slice, with start/done handshake, subtract mode and status flags. Next generation of the team's fixed 4-bit ripple full adder. Serves as the shared ALU add path where area matters more than latency.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of CHUNK, ≥ CHUNK.
- CHUNK, 4: bits added per cycle; N = WIDTH/CHUNK cycles per operation.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only on an edge where busy=0.
- SUB  in  1  0 = A+B+CI; 1 = A−B (A + ~B + 1, CI ignored); sampled with start.
- A, B  in  WIDTH  operands, sampled with start only.
- CI  in  1  carry-in for add, sampled with start.
- busy  out  1  high while slices are being processed.
- done  out  1  one-cycle pulse, result valid.
- S  out  WIDTH  result; holds until the next accepted start completes.
- CO  out  1  final carry out (subtract: 1 = no borrow).
- OV  out  1  two's-complement overflow.
- ZF  out  1  S == 0.

## Operation
- States: IDLE, RUN, DONE. Slice counter cnt, 0..N−1.
- IDLE/DONE + start: latch A; latch Beff = SUB ? ~B : B; carry = SUB ? 1 : CI; cnt = 0; go RUN.
- RUN, each edge: slice cnt of A and Beff plus carry go through chunk_adder; its sum is written to S[cnt*CHUNK +: CHUNK]; carry register takes its carry out; cnt++. At cnt == N−1 go DONE.
- DONE: done=1 for exactly one cycle. CO = final carry. OV = (A[MSB] == Beff[MSB]) & (S[MSB] != A[MSB]). ZF = ~|S. Then IDLE, unless start is asserted (accepted, go RUN).
- start while busy=1: ignored, with no effect on operands or the counter.
- S, CO, OV and ZF hold their last completed values in IDLE. S is partially overwritten during RUN; it is only valid when done=1 and afterwards.
- rst: state IDLE, cnt=0, busy=0, done=0, S=0, CO=0, OV=0, ZF=0. Takes priority over start. A reset mid-RUN aborts the operation with no done pulse.

## Timing
- start sampled at edge k. busy=1 from k through k+N−1. done=1 in the cycle after edge k+N.
- Latency: N+1 edges from start to done. Throughput: one operation per N+1 cycles.
- With N=1 (CHUNK=WIDTH): RUN lasts one edge and done is high after edge k+1.
- Back-to-back: start held high in the DONE cycle begins the next operation. busy rises on the following edge.
- Flags update on the same edge as done rises. They are registered, with no combinational path from the inputs.

## Structure
- Shared header adder_defs.vh: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH/CHUNK values.
- Sub-module chunk_adder (parameter SIZE=CHUNK): combinational SIZE-bit ripple adder with ports A, B, CI, S, CO. Instantiated once and reused each cycle.
- Top level holds the FSM, counter, operand registers, carry register, result register and flag logic.

## Test plan
- WIDTH=16, CHUNK=4, A=0x1234, B=0x1111, CI=0, SUB=0 → S=0x2345, CO=0, OV=0, ZF=0; done 5 edges after start, busy high for 4 cycles.
- A=0xFFFF, B=0x0001, CI=0 → S=0x0000, CO=1, ZF=1, OV=0. A=0x7FFF, B=0x0001 → S=0x8000, OV=1, CO=0.
- SUB=1, A=0x0005, B=0x0007 → S=0xFFFE, CO=0, OV=0. SUB=1, A=0x8000, B=0x0001 → S=0x7FFF, OV=1, CO=1.
- start pulsed mid-RUN with different operands → ignored; first result unchanged. start held in the DONE cycle → second operation completes N+1 edges later.
- rst asserted in the 2nd RUN cycle → next cycle busy=0, S=0, flags 0, no done pulse. A new start afterwards completes normally.
- CHUNK=WIDTH=4: A=0x9, B=0x8, CI=1 → S=0x2, CO=1, OV=1; done 2 edges after start.

Source files
------------

// File: rtl/multi_cycle_adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM state encoding,
// default geometry and a helper for sizing the slice counter.
package multi_cycle_adder_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter needs at least one bit even when a single slice covers the word.
   function automatic int cnt_width(input int n_slices);
      return (n_slices > 1) ? $clog2(n_slices) : 1;
   endfunction

endpackage

// File: rtl/multi_cycle_adder_if.sv
// Request/result bundle between a client and the multi-cycle adder.
interface multi_cycle_adder_if import multi_cycle_adder_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic             start;
   logic             SUB;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CI;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             CO;
   logic             OV;
   logic             ZF;

   modport master (
      output start, SUB, A, B, CI,
      input  busy, done, S, CO, OV, ZF
   );

   modport slave (
      input  start, SUB, A, B, CI,
      output busy, done, S, CO, OV, ZF
   );

endinterface

// File: rtl/multi_cycle_adder_chunk_adder.sv
// Combinational SIZE-bit ripple-carry adder slice, reused every cycle by the
// multi-cycle adder.
module chunk_adder #(
   parameter int SIZE = 4
) (
   input  logic [SIZE-1:0] A,
   input  logic [SIZE-1:0] B,
   input  logic            CI,
   output logic [SIZE-1:0] S,
   output logic            CO
);

   logic [SIZE:0] w_c;

   assign w_c[0] = CI;

   for (genvar i = 0; i < SIZE; i++) begin : g_bit
      assign S[i]     = A[i] ^ B[i] ^ w_c[i];
      assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
   end

   assign CO = w_c[SIZE];

endmodule

// File: rtl/multi_cycle_adder.sv
// Sequential adder/subtractor: WIDTH-bit operands processed CHUNK bits per
// clock through a single chunk_adder, with start/done handshake and flags.
//
// state | meaning
// IDLE  | waiting for start; result and flags hold last completed values
// RUN   | one slice added per edge, slice index in r_cnt
// DONE  | done pulse; result and flags valid; start here chains next op
module multi_cycle_adder import multi_cycle_adder_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic              clk,
   input  logic              rst,
   multi_cycle_adder_if.slave bus
);

   localparam int N   = WIDTH / CHUNK;
   localparam int CW  = cnt_width(N);
   localparam int MSB = WIDTH - 1;

   state_t           r_state;
   state_t           w_state_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_s;
   logic             r_carry;
   logic             r_co;
   logic             r_ov;
   logic             r_zf;

   logic             w_accept;
   logic             w_last;
   logic [CHUNK-1:0] w_a_slice;
   logic [CHUNK-1:0] w_b_slice;
   logic [CHUNK-1:0] w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_s_next;

   assign w_accept = bus.start && (r_state != ST_RUN);
   assign w_last   = (r_cnt == CW'(N - 1));

   // Slice select and write-back use constant indices to keep the mux explicit.
   always_comb begin
      w_a_slice = '0;
      w_b_slice = '0;
      w_s_next  = r_s;
      for (int i = 0; i < N; i++) begin
         if (r_cnt == CW'(i)) begin
            w_a_slice                   = r_a[i*CHUNK +: CHUNK];
            w_b_slice                   = r_b[i*CHUNK +: CHUNK];
            w_s_next[i*CHUNK +: CHUNK]  = w_sum;
         end
      end
   end

   chunk_adder #(.SIZE(CHUNK)) u_chunk (
      .A  (w_a_slice),
      .B  (w_b_slice),
      .CI (r_carry),
      .S  (w_sum),
      .CO (w_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.start) w_state_next = ST_RUN;
         ST_RUN:  if (w_last)    w_state_next = ST_DONE;
         ST_DONE: w_state_next = bus.start ? ST_RUN : ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_s     <= '0;
         r_carry <= 1'b0;
         r_co    <= 1'b0;
         r_ov    <= 1'b0;
         r_zf    <= 1'b0;
      end else if (w_accept) begin
         r_a     <= bus.A;
         r_b     <= bus.SUB ? ~bus.B : bus.B;
         r_carry <= bus.SUB | bus.CI;
         r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
         r_s     <= w_s_next;
         r_carry <= w_cout;
         r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
         // Flags land on the same edge that enters DONE.
         if (w_last) begin
            r_co <= w_cout;
            r_ov <= (r_a[MSB] == r_b[MSB]) && (w_s_next[MSB] != r_a[MSB]);
            r_zf <= ~|w_s_next;
         end
      end
   end

   assign bus.busy = (r_state == ST_RUN);
   assign bus.done = (r_state == ST_DONE);
   assign bus.S    = r_s;
   assign bus.CO   = r_co;
   assign bus.OV   = r_ov;
   assign bus.ZF   = r_zf;

endmodule
